mppt_po_dpwm: RTL

- Parametrised perturb-and-observe MPPT controller with an integrated glitch-free DPWM.
- Separate voltage and current ADC inputs with an explicit sample strobe.
- Programmable step size and duty limits; track, hold and fixed modes.
- Sits between the LA/ADC sample interface and the converter gate-drive pad (one instance per converter channel).

---
 rtl/mppt_po_dpwm.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mppt_po_dpwm.sv
`default_nettype none
// ---- mppt_po_dpwm : perturb-and-observe MPPT controller with glitch-free DPWM ----
// Revision 1.0 - initial release
module mppt_po_dpwm #(
  parameter int ADC_W          = 12,
  parameter int DUTY_W         = 8,
  parameter int SETTLE_PERIODS = 4,
  parameter int DUTY_INIT      = 128
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [ADC_W-1:0]     v_in,
  input  logic [ADC_W-1:0]     i_in,
  input  logic                 sample_valid,
  input  logic [DUTY_W-1:0]    step,
  input  logic [DUTY_W-1:0]    duty_min,
  input  logic [DUTY_W-1:0]    duty_max,
  input  logic [DUTY_W-1:0]    duty_fixed,
  output logic                 pwm,
  output logic [DUTY_W-1:0]    duty,
  output logic [2*ADC_W-1:0]   power,
  output logic                 dir,
  output logic                 update
);

  localparam int SW = $clog2(SETTLE_PERIODS + 1);
  localparam logic [SW-1:0]            c_settle_last = SW'(SETTLE_PERIODS - 1);
  localparam logic signed [DUTY_W+1:0] c_duty_init   = (DUTY_W+2)'(DUTY_INIT);
  localparam logic [1:0]               c_mode_track  = 2'b00;
  localparam logic [1:0]               c_mode_fixed  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_WAIT_S = 3'd2,
    S_CALC   = 3'd3,
    S_UPDATE = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DUTY_W-1:0]    r_cnt;
  logic [DUTY_W-1:0]    r_duty_act;
  logic [DUTY_W-1:0]    r_duty;
  logic [2*ADC_W-1:0]   r_power;
  logic [2*ADC_W-1:0]   r_pprev;
  logic                 r_pvalid;
  logic                 r_dir;
  logic                 r_update;
  logic [SW-1:0]        r_settle;

  logic                     w_wrap;
  logic                     w_settle_done;
  logic [2*ADC_W-1:0]       w_prod;
  logic signed [DUTY_W+1:0] w_nd;
  logic [DUTY_W-1:0]        w_nd_cl;
  logic                     w_nd_hit;

  // Signed, two guard bits wide, so a decrement below zero clamps to duty_min.
  function automatic logic [DUTY_W-1:0] f_clamp(input logic signed [DUTY_W+1:0] x,
                                                input logic [DUTY_W-1:0] lo,
                                                input logic [DUTY_W-1:0] hi);
    logic signed [DUTY_W+1:0] v;
    v = x;
    if (v > $signed({2'b00, hi})) v = $signed({2'b00, hi});
    if (v < $signed({2'b00, lo})) v = $signed({2'b00, lo});
    return DUTY_W'(v);
  endfunction

  assign w_wrap        = (r_cnt == {DUTY_W{1'b1}});
  assign w_settle_done = w_wrap && (r_settle == c_settle_last);
  assign w_prod        = (2*ADC_W)'(v_in) * (2*ADC_W)'(i_in);
  assign w_nd          = r_dir ? ($signed({2'b00, r_duty}) + $signed({2'b00, step}))
                               : ($signed({2'b00, r_duty}) - $signed({2'b00, step}));
  assign w_nd_cl       = f_clamp(w_nd, duty_min, duty_max);
  assign w_nd_hit      = ($signed({2'b00, w_nd_cl}) != w_nd);

  assign pwm    = enable && (r_cnt < r_duty_act);
  assign duty   = r_duty;
  assign power  = r_power;
  assign dir    = r_dir;
  assign update = r_update;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (enable) w_state_nxt = S_SETTLE;
      S_SETTLE: if (w_settle_done) w_state_nxt = S_WAIT_S;
      S_WAIT_S: if (sample_valid) w_state_nxt = S_CALC;
      S_CALC:   w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = S_SETTLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (!enable) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cnt      <= '0;
      r_duty_act <= '0;
      r_duty     <= '0;
      r_power    <= '0;
      r_pprev    <= '0;
      r_pvalid   <= 1'b0;
      r_dir      <= 1'b1;
      r_update   <= 1'b0;
      r_settle   <= '0;
    end else begin
      r_cnt    <= r_cnt + 1'b1;
      r_update <= 1'b0;
      // Active duty only changes at the period boundary: no runt pulses.
      if (w_wrap) r_duty_act <= r_duty;
      case (r_state)
        S_IDLE: begin
          r_duty   <= '0;
          r_pvalid <= 1'b0;
          r_settle <= '0;
          if (enable) begin
            r_duty <= f_clamp(c_duty_init, duty_min, duty_max);
            r_dir  <= 1'b1;
          end
        end
        S_SETTLE: if (w_wrap) r_settle <= r_settle + 1'b1;
        S_WAIT_S: if (sample_valid) r_power <= w_prod;
        S_CALC: begin
          if (mode == c_mode_track && r_pvalid && r_power < r_pprev) r_dir <= ~r_dir;
          r_pprev  <= r_power;
          r_pvalid <= 1'b1;
        end
        S_UPDATE: begin
          if (mode == c_mode_track) begin
            r_duty <= w_nd_cl;
            if (w_nd_hit) r_dir <= ~r_dir;
          end else if (mode == c_mode_fixed) begin
            r_duty <= f_clamp($signed({2'b00, duty_fixed}), duty_min, duty_max);
          end
          r_update <= 1'b1;
          r_settle <= '0;
        end
        default: ;
      endcase
      if (!enable) begin
        r_duty   <= '0;
        r_pvalid <= 1'b0;
        r_update <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
